// File: rtl/count_down_timer.sv
`default_nettype none
// ============================================================================
// Module  : count_down_timer
// Brief   : Loadable down-counting timer with one-shot/periodic modes and
//           pause/resume.
// Revision: 1.0
// ============================================================================
module count_down_timer #(
  parameter int SIZE = 8
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            load_i,
  input  logic [SIZE-1:0] value_i,
  input  logic            start_i,
  input  logic            stop_i,
  input  logic            tick_i,
  input  logic            periodic_i,
  output logic [SIZE-1:0] data_o,
  output logic            busy_o,
  output logic            paused_o,
  output logic            expired_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2
  } state_t;

  localparam logic [SIZE-1:0] c_ZERO = '0;
  localparam logic [SIZE-1:0] c_ONE  = {{(SIZE-1){1'b0}}, 1'b1};

  state_t          r_state;
  logic [SIZE-1:0] r_count;
  logic [SIZE-1:0] r_reload;
  logic            r_expired;

  state_t          w_state_nxt;
  logic [SIZE-1:0] w_count_nxt;
  logic [SIZE-1:0] w_reload_nxt;
  logic            w_expired_nxt;
  logic [SIZE-1:0] w_eff_count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_count   <= c_ZERO;
      r_reload  <= c_ZERO;
      r_expired <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_count   <= w_count_nxt;
      r_reload  <= w_reload_nxt;
      r_expired <= w_expired_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_count_nxt   = r_count;
    w_reload_nxt  = load_i ? value_i : r_reload;
    w_expired_nxt = 1'b0;
    w_eff_count   = load_i ? value_i : r_count;

    case (r_state)
      S_IDLE: begin
        w_count_nxt = w_eff_count;
        if (start_i) begin
          if (w_eff_count == c_ZERO) w_expired_nxt = 1'b1;
          else                       w_state_nxt   = S_RUN;
        end
      end
      S_RUN: begin
        // A load while running only retargets the next auto-reload.
        if (stop_i) begin
          w_state_nxt = S_PAUSE;
        end else if (tick_i) begin
          if (r_count > c_ONE) begin
            w_count_nxt = r_count - c_ONE;
          end else if (r_count == c_ONE) begin
            w_expired_nxt = 1'b1;
            if (periodic_i && (r_reload != c_ZERO)) begin
              w_count_nxt = r_reload;
            end else begin
              w_count_nxt = c_ZERO;
              w_state_nxt = S_IDLE;
            end
          end
        end
      end
      S_PAUSE: begin
        w_count_nxt = w_eff_count;
        if (stop_i)       w_state_nxt = S_IDLE;
        else if (start_i) w_state_nxt = S_RUN;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign data_o    = r_count;
  assign busy_o    = (r_state == S_RUN);
  assign paused_o  = (r_state == S_PAUSE);
  assign expired_o = r_expired;

endmodule
`default_nettype wire

// File: tb/tb_count_down_timer.sv
`default_nettype none
// ============================================================================
// Module  : tb_count_down_timer
// Brief   : Scoreboard bench for count_down_timer against a behavioural model.
// Revision: 1.0
// ============================================================================
module tb_count_down_timer;

  localparam int SIZE = 8;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic            load_i = 1'b0;
  logic [SIZE-1:0] value_i = '0;
  logic            start_i = 1'b0;
  logic            stop_i = 1'b0;
  logic            tick_i = 1'b0;
  logic            periodic_i = 1'b0;
  logic [SIZE-1:0] data_o;
  logic            busy_o;
  logic            paused_o;
  logic            expired_o;

  count_down_timer #(.SIZE(SIZE)) dut (
    .clock      (clock),
    .reset      (reset),
    .load_i     (load_i),
    .value_i    (value_i),
    .start_i    (start_i),
    .stop_i     (stop_i),
    .tick_i     (tick_i),
    .periodic_i (periodic_i),
    .data_o     (data_o),
    .busy_o     (busy_o),
    .paused_o   (paused_o),
    .expired_o  (expired_o)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [SIZE-1:0] cnt;
    logic            busy;
    logic            paused;
    logic            expired;
  } exp_t;

  exp_t q_exp[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model: mode 0 idle, 1 running, 2 paused.
  int m_mode = 0;
  int m_cnt  = 0;
  int m_rel  = 0;
  bit m_exp  = 0;

  task automatic model_step(input bit ld, input int v, input bit st, input bit sp,
                            input bit tk, input bit pr, input bit rn);
    int nc;
    int nm;
    bit ne;
    if (!rn) begin
      m_mode = 0; m_cnt = 0; m_rel = 0; m_exp = 0;
    end else begin
      nc = m_cnt; nm = m_mode; ne = 0;
      if (m_mode == 0) begin
        if (ld) nc = v;
        if (st) begin
          if (nc == 0) ne = 1;
          else         nm = 1;
        end
      end else if (m_mode == 1) begin
        if (sp) nm = 2;
        else if (tk && m_cnt > 1) nc = m_cnt - 1;
        else if (tk && m_cnt == 1) begin
          ne = 1;
          if (pr && m_rel != 0) nc = m_rel;
          else begin nc = 0; nm = 0; end
        end
      end else begin
        if (ld) nc = v;
        if (sp)      nm = 0;
        else if (st) nm = 1;
      end
      if (ld) m_rel = v;
      m_cnt = nc; m_mode = nm; m_exp = ne;
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.cnt     = m_cnt[SIZE-1:0];
    e.busy    = (m_mode == 1);
    e.paused  = (m_mode == 2);
    e.expired = m_exp;
    return e;
  endfunction

  task automatic cyc(input bit ld, input int v, input bit st, input bit sp,
                     input bit tk, input bit pr, input bit rn = 1'b1);
    @(negedge clock);
    reset      = rn;
    load_i     = ld;
    value_i    = v[SIZE-1:0];
    start_i    = st;
    stop_i     = sp;
    tick_i     = tk;
    periodic_i = pr;
    model_step(ld, v, st, sp, tk, pr, rn);
    q_exp.push_back(model_out());
  endtask

  task automatic check_now(input string name, input exp_t e);
    vectors++;
    if ({data_o, busy_o, paused_o, expired_o} !== e) begin
      miscompares++;
      $display("FAIL %s: got data_o=%0d busy=%b paused=%b expired=%b, required %0d %b %b %b",
               name, data_o, busy_o, paused_o, expired_o, e.cnt, e.busy, e.paused, e.expired);
    end
  endtask

  // Monitor: one registered response per rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (q_exp.size() > 0) begin
        e = q_exp.pop_front();
        check_now("cycle_check", e);
      end
    end
  end

  task automatic async_reset_mid_cycle();
    @(negedge clock);
    #2 reset = 1'b0;
    #1 model_step(0, 0, 0, 0, 0, 0, 0);
    check_now("async_reset", model_out());
    q_exp.push_back(model_out());
  endtask

  initial begin
    #3 reset = 1'b0;
    #1 check_now("reset_state", exp_t'(0));
    cyc(0, 0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 1);

    // One-shot countdown from 3
    cyc(1, 3, 1, 0, 0, 0);
    repeat (5) cyc(0, 0, 0, 0, 1, 0);

    // Periodic reload of 2, then pause and abort
    cyc(1, 2, 1, 0, 0, 1);
    repeat (6) cyc(0, 0, 0, 0, 1, 1);
    cyc(0, 0, 0, 1, 1, 1);
    cyc(0, 0, 0, 1, 0, 1);

    // Start with zero count
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    repeat (2) cyc(0, 0, 0, 0, 1, 0);

    // Pause holds the count across ticks, resume finishes it
    cyc(1, 5, 1, 0, 0, 0);
    repeat (2) cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 0, 0);
    repeat (4) cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 0, 1, 0, 0, 0);
    repeat (3) cyc(0, 0, 0, 0, 1, 0);
    repeat (2) cyc(0, 0, 0, 0, 0, 0);

    // Start and stop together: RUN->PAUSE->IDLE
    cyc(1, 4, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 0, 1, 1, 0, 0);
    cyc(0, 0, 1, 1, 0, 0);
    cyc(0, 0, 0, 0, 1, 0);

    // Asynchronous reset while running with 7
    cyc(1, 7, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    async_reset_mid_cycle();
    repeat (2) cyc(0, 0, 0, 0, 1, 0, 0);
    repeat (3) cyc(0, 0, 0, 0, 1, 0);

    // Randomised traffic with small values so expiry is frequent
    for (int i = 0; i < 3000; i++) begin
      bit ld, st, sp, tk, pr;
      int v;
      ld = ($urandom_range(0, 99) < 10);
      st = ($urandom_range(0, 99) < 15);
      sp = ($urandom_range(0, 99) < 5);
      tk = ($urandom_range(0, 99) < 70);
      pr = ((i / 200) % 2 == 1);
      v  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 6));
      cyc(ld, v, st, sp, tk, pr);
    end

    for (int k = 0; k < 10 && q_exp.size() > 0; k++) @(posedge clock);
    @(negedge clock);
    if (q_exp.size() > 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain: %0d expectations left, required 0", q_exp.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
